// File: rtl/chess_cmd_pkg.sv
// Shared definitions for the chess board command sequencer.
// Holds opcode and MISC-operand encodings, the board state-mode (SM_*)
// and mask-mode (MM_*) enumerations, and a helper that maps a mask
// opcode onto its mask mode.
package chess_cmd_pkg;

  localparam logic [3:0] OP_NOP        = 4'h0;
  localparam logic [3:0] OP_MISC       = 4'h1;
  localparam logic [3:0] OP_SET_SS1    = 4'h3;
  localparam logic [3:0] OP_PUSH_SS1   = 4'h6;
  localparam logic [3:0] OP_POP_SS1    = 4'h7;
  localparam logic [3:0] OP_MM_DV_EAA  = 4'h8;
  localparam logic [3:0] OP_MM_DA      = 4'h9;
  localparam logic [3:0] OP_FIND_AGG   = 4'hA;
  localparam logic [3:0] OP_SET_SQ     = 4'hB;
  localparam logic [3:0] OP_MM_EAV_EAA = 4'hC;
  localparam logic [3:0] OP_FP         = 4'hD;
  localparam logic [3:0] OP_FA         = 4'hE;
  localparam logic [3:0] OP_FV         = 4'hF;

  localparam logic [3:0] MISC_CLR_ERR  = 4'h0;
  localparam logic [3:0] MISC_WTM0     = 4'h4;
  localparam logic [3:0] MISC_WTM1     = 4'h5;

  typedef enum logic [2:0] {
    SM_IDLE = 3'd0,
    SM_W    = 3'd1,
    SM_FP   = 3'd2,
    SM_FA   = 3'd3,
    SM_FV   = 3'd4
  } sm_e;

  typedef enum logic [1:0] {
    MM_NO_CHANGE = 2'd0,
    MM_DV_EAA    = 2'd1,
    MM_DA        = 2'd2,
    MM_EAV_EAA   = 2'd3
  } mm_e;

  function automatic mm_e op_to_mm(input logic [3:0] op);
    case (op)
      OP_MM_DV_EAA:  return MM_DV_EAA;
      OP_MM_DA:      return MM_DA;
      OP_MM_EAV_EAA: return MM_EAV_EAA;
      default:       return MM_NO_CHANGE;
    endcase
  endfunction

endpackage

// File: rtl/ss_stack.sv
// LIFO holding saved ss1 values.
// Ports: clk/rst_n (async active-low), push/pop requests, din (value to
// push), dout (current top, meaningless when empty), full, empty.
// A push while full or a pop while empty is ignored here; the caller
// flags the error.
module ss_stack #(
  parameter int SS_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic       pop,
  input  logic [5:0] din,
  output logic [5:0] dout,
  output logic       full,
  output logic       empty
);

  localparam int CW = $clog2(SS_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(SS_DEPTH);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  // Power-of-two sized storage so every CW-bit index is in range.
  logic [5:0]    mem [0:(1<<CW)-1];
  logic [CW-1:0] cnt;
  logic [CW-1:0] top;

  assign full  = (cnt == DEPTH_C);
  assign empty = (cnt == '0);
  assign top   = cnt - ONE_C;
  assign dout  = mem[top];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (push && !full) begin
      cnt <= cnt + ONE_C;
    end else if (pop && !empty) begin
      cnt <= cnt - ONE_C;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem[cnt] <= din;
  end

endmodule

// File: rtl/chess_cmd_seq.sv
// Command sequencer between an SPI nybble link and the chess board logic.
// Ports: clk/rst_n (async active-low); din/din_valid command and operand
// nybbles; dout/dout_valid/dout_ack response beats (OUT_W wide);
// state_mode, mask_mode, wtm, write_bus, ss1 board controls; board_data
// and board_illegal board result; err sticky protocol/stack error.
module chess_cmd_seq
  import chess_cmd_pkg::*;
#(
  parameter int OUT_W    = 4,
  parameter int SS_DEPTH = 4,
  parameter int MAX_ITER = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       din,
  input  logic             din_valid,
  output logic [OUT_W-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ack,
  output logic [2:0]       state_mode,
  output logic [1:0]       mask_mode,
  output logic             wtm,
  output logic [3:0]       write_bus,
  output logic [5:0]       ss1,
  input  logic [6:0]       board_data,
  input  logic             board_illegal,
  output logic             err
);

  localparam int IW = $clog2(MAX_ITER + 1);
  localparam logic [IW-1:0] ITER_MAX_C = IW'(MAX_ITER);
  localparam logic [IW-1:0] ITER_ONE_C = IW'(1);
  localparam bit ONE_BEAT = (OUT_W == 8);

  typedef enum logic [3:0] {
    S_IDLE, S_MISC, S_SS1_HI, S_SS1_LO, S_SQ_OP, S_SQ_W,
    S_MASK, S_SETTLE, S_SEND, S_DA
  } state_t;

  state_t        state, state_nx;
  sm_e           kind_sm;   // board mode of the running fetch command
  logic          faa;       // running command is FIND-ALL-AGG
  mm_e           mm_sel;
  logic [7:0]    r;         // captured {illegal, data}
  logic          beat;      // 0 = high nybble pending, 1 = low nybble
  logic [5:0]    saved;     // ss1 at command start, restored at the end
  logic [1:0]    ss1_hi;
  logic [IW-1:0] iter;

  logic       op_go, push, pop, st_full, st_empty;
  logic [5:0] st_top;
  logic       last_beat, done_last, faa_stop, err_set, err_clr;

  assign op_go     = din_valid && (state == S_IDLE);
  assign push      = op_go && (din == OP_PUSH_SS1);
  assign pop       = op_go && (din == OP_POP_SS1);
  assign last_beat = ONE_BEAT | beat;
  assign done_last = (state == S_SEND) && dout_ack && last_beat;
  // Aggressor search ends on an illegal result or when the cap is reached.
  assign faa_stop  = r[7] || (iter == ITER_MAX_C);

  assign err_set = (din_valid && (state == S_SETTLE || state == S_SEND ||
                                  state == S_DA))
                 || (push && st_full) || (pop && st_empty);
  assign err_clr = (state == S_MISC) && din_valid && (din == MISC_CLR_ERR);

  ss_stack #(.SS_DEPTH(SS_DEPTH)) u_stack (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (ss1),
    .dout  (st_top),
    .full  (st_full),
    .empty (st_empty)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (din_valid) begin
        case (din)
          OP_MISC:                              state_nx = S_MISC;
          OP_SET_SS1:                           state_nx = S_SS1_HI;
          OP_SET_SQ:                            state_nx = S_SQ_OP;
          OP_MM_DV_EAA, OP_MM_DA, OP_MM_EAV_EAA: state_nx = S_MASK;
          OP_FIND_AGG, OP_FP, OP_FA, OP_FV:     state_nx = S_SETTLE;
          default:                              state_nx = S_IDLE;
        endcase
      end
      S_MISC:   if (din_valid) state_nx = S_IDLE;
      S_SS1_HI: if (din_valid) state_nx = S_SS1_LO;
      S_SS1_LO: if (din_valid) state_nx = S_IDLE;
      S_SQ_OP:  if (din_valid) state_nx = S_SQ_W;
      S_SQ_W:   state_nx = S_IDLE;
      S_MASK:   state_nx = S_IDLE;
      S_SETTLE: state_nx = S_SEND;
      S_SEND: if (done_last) begin
        if (kind_sm == SM_FA && (!faa || !faa_stop)) state_nx = S_DA;
        else                                          state_nx = S_IDLE;
      end
      S_DA:     state_nx = faa ? S_SETTLE : S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  // Outputs decoded from state. The fetch mode is held only while the
  // board result is settling or being sent.
  always_comb begin
    state_mode = SM_IDLE;
    mask_mode  = MM_NO_CHANGE;
    dout_valid = 1'b0;
    case (state)
      S_SQ_W:           state_mode = SM_W;
      S_SETTLE:         state_mode = kind_sm;
      S_SEND: begin
        state_mode = kind_sm;
        dout_valid = 1'b1;
      end
      S_MASK:           mask_mode = mm_sel;
      S_DA:             mask_mode = MM_DA;
      default: ;
    endcase
  end

  generate
    if (ONE_BEAT) begin : g_one_beat
      assign dout = r;
    end else begin : g_two_beat
      assign dout = beat ? r[3:0] : r[7:4];
    end
  endgenerate

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kind_sm   <= SM_IDLE;
      faa       <= 1'b0;
      mm_sel    <= MM_NO_CHANGE;
      r         <= '0;
      beat      <= 1'b0;
      saved     <= '0;
      ss1_hi    <= '0;
      iter      <= '0;
      ss1       <= '0;
      wtm       <= 1'b0;
      write_bus <= '0;
      err       <= 1'b0;
    end else begin
      if (op_go) begin
        case (din)
          OP_FP:       begin kind_sm <= SM_FP; faa <= 1'b0; end
          OP_FV:       begin kind_sm <= SM_FV; faa <= 1'b0; end
          OP_FA:       begin kind_sm <= SM_FA; faa <= 1'b0; end
          OP_FIND_AGG: begin kind_sm <= SM_FA; faa <= 1'b1; end
          OP_POP_SS1:  if (!st_empty) ss1 <= st_top;
          default: ;
        endcase
        mm_sel <= op_to_mm(din);
        saved  <= ss1;
        iter   <= '0;
      end
      if (din_valid) begin
        case (state)
          S_MISC: begin
            if (din == MISC_WTM0) wtm <= 1'b0;
            if (din == MISC_WTM1) wtm <= 1'b1;
          end
          S_SS1_HI: ss1_hi    <= din[1:0];
          S_SS1_LO: ss1       <= {ss1_hi, din};
          S_SQ_OP:  write_bus <= din;
          default: ;
        endcase
      end
      if (state == S_SETTLE) begin
        r    <= {board_illegal, board_data};
        beat <= 1'b0;
        iter <= iter + ITER_ONE_C;
      end
      if (state == S_SEND && dout_ack) begin
        if (!last_beat)               beat <= 1'b1;
        else if (faa && faa_stop)     ss1  <= saved;
        else                          ss1  <= r[5:0];
      end
      if (state == S_DA && !faa) ss1 <= saved;
      // Set has priority over a simultaneous MISC clear.
      if (err_set)      err <= 1'b1;
      else if (err_clr) err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_chess_cmd_seq.sv
module tb_chess_cmd_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] din = '0;
  logic [6:0] board_data = '0;
  logic       board_illegal = 1'b0;

  // u4: two-beat responses, shallow stack
  logic       dv4 = 1'b0, ack4 = 1'b0;
  logic [3:0] dout4;
  logic       dval4, wtm4, err4;
  logic [2:0] sm4;
  logic [1:0] mm4;
  logic [3:0] wb4;
  logic [5:0] ss4;

  // u8: one-beat responses, small iteration cap
  logic       dv8 = 1'b0, ack8 = 1'b0;
  logic [7:0] dout8;
  logic       dval8, wtm8, err8;
  logic [2:0] sm8;
  logic [1:0] mm8;
  logic [3:0] wb8;
  logic [5:0] ss8;

  int checks = 0;
  int failures = 0;

  chess_cmd_seq #(.OUT_W(4), .SS_DEPTH(2), .MAX_ITER(16)) u4 (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(dv4),
    .dout(dout4), .dout_valid(dval4), .dout_ack(ack4),
    .state_mode(sm4), .mask_mode(mm4), .wtm(wtm4), .write_bus(wb4),
    .ss1(ss4), .board_data(board_data), .board_illegal(board_illegal),
    .err(err4));

  chess_cmd_seq #(.OUT_W(8), .SS_DEPTH(4), .MAX_ITER(3)) u8 (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(dv8),
    .dout(dout8), .dout_valid(dval8), .dout_ack(ack8),
    .state_mode(sm8), .mask_mode(mm8), .wtm(wtm8), .write_bus(wb8),
    .ss1(ss8), .board_data(board_data), .board_illegal(board_illegal),
    .err(err8));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One-cycle din pulse; returns on the negedge after it was consumed.
  task automatic send(input int which, input logic [3:0] v);
    din = v;
    if (which == 4) dv4 = 1'b1; else dv8 = 1'b1;
    @(negedge clk);
    dv4 = 1'b0;
    dv8 = 1'b0;
  endtask

  task automatic ack(input int which);
    if (which == 4) ack4 = 1'b1; else ack8 = 1'b1;
    @(negedge clk);
    ack4 = 1'b0;
    ack8 = 1'b0;
  endtask

  initial begin
    // Reset values
    @(negedge clk); @(negedge clk);
    chk("rst_dout", dout4, 0);     chk("rst_dval", dval4, 0);
    chk("rst_sm", sm4, 0);         chk("rst_mm", mm4, 0);
    chk("rst_wtm", wtm4, 0);       chk("rst_wb", wb4, 0);
    chk("rst_ss1", ss4, 0);        chk("rst_err", err4, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // SET-SS1 and MISC
    send(4, 4'h3); send(4, 4'h2);
    chk("ss1_not_yet", ss4, 0);
    send(4, 4'h5);
    chk("ss1_set", ss4, 6'h25);
    send(4, 4'h1); send(4, 4'h5);
    chk("wtm_set", wtm4, 1);

    // Mask opcode: one cycle
    send(4, 4'h8);
    chk("mask_dv_eaa", mm4, 1);
    @(negedge clk);
    chk("mask_back", mm4, 0);

    // SET-SQUARE
    send(4, 4'hB); send(4, 4'h7);
    chk("sq_sm_w", sm4, 1);  chk("sq_wb", wb4, 4'h7);
    @(negedge clk);
    chk("sq_sm_idle", sm4, 0); chk("sq_wb_hold", wb4, 4'h7);

    // FP, two beats with stalled ack and a discarded din
    board_data = 7'h1C; board_illegal = 1'b0;
    send(4, 4'hD);
    chk("fp_settle_sm", sm4, 2); chk("fp_settle_val", dval4, 0);
    @(negedge clk);
    chk("fp_b0", dout4, 4'h1); chk("fp_b0_val", dval4, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("fp_stall", dout4, 4'h1);
    end
    send(4, 4'h0);
    chk("resp_din_err", err4, 1); chk("fp_stall2", dout4, 4'h1);
    ack(4);
    chk("fp_b1", dout4, 4'hC); chk("fp_b1_val", dval4, 1);
    ack(4);
    chk("fp_done_val", dval4, 0); chk("fp_ss1", ss4, 6'h1C);
    chk("fp_sm_idle", sm4, 0);

    // FIND-ALL-AGG: 0x05, 0x09, then illegal 0x12 -> R=0x92
    board_data = 7'h05;
    send(4, 4'hA);
    @(negedge clk);
    chk("faa1_b0", dout4, 4'h0);
    ack(4);
    chk("faa1_b1", dout4, 4'h5);
    ack(4);
    chk("faa1_da", mm4, 2); chk("faa1_ss1", ss4, 6'h05); chk("faa1_val", dval4, 0);
    board_data = 7'h09;
    @(negedge clk);
    chk("faa2_settle_sm", sm4, 3); chk("faa2_mm", mm4, 0);
    @(negedge clk);
    chk("faa2_b0", dout4, 4'h0);
    ack(4);
    chk("faa2_b1", dout4, 4'h9);
    ack(4);
    chk("faa2_da", mm4, 2); chk("faa2_ss1", ss4, 6'h09);
    board_data = 7'h12; board_illegal = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("faa3_b0", dout4, 4'h9); chk("faa3_val", dval4, 1);
    ack(4);
    chk("faa3_b1", dout4, 4'h2);
    ack(4);
    chk("faa_end_mm", mm4, 0); chk("faa_end_val", dval4, 0);
    chk("faa_restore", ss4, 6'h1C);
    board_illegal = 1'b0;

    // Stack: clear err, fill, overflow, underflow
    send(4, 4'h1); send(4, 4'h0);
    chk("err_clr", err4, 0);
    send(4, 4'h6);
    send(4, 4'h3); send(4, 4'h2); send(4, 4'hA);
    send(4, 4'h6);
    chk("push_ok_err", err4, 0);
    send(4, 4'h6);
    chk("push_full_err", err4, 1);
    send(4, 4'h1); send(4, 4'h0);
    chk("err_clr2", err4, 0);
    send(4, 4'h3); send(4, 4'h3); send(4, 4'hF);
    send(4, 4'h7);
    chk("pop1", ss4, 6'h2A);
    send(4, 4'h7);
    chk("pop2", ss4, 6'h1C); chk("pop2_err", err4, 0);
    send(4, 4'h7);
    chk("pop_empty_ss1", ss4, 6'h1C); chk("pop_empty_err", err4, 1);

    // u8: FA single
    send(8, 4'h3); send(8, 4'h1); send(8, 4'h0);
    chk("u8_ss1", ss8, 6'h10);
    board_data = 7'h33;
    send(8, 4'hE);
    chk("fa_settle_sm", sm8, 3);
    @(negedge clk);
    chk("fa_beat", dout8, 8'h33); chk("fa_val", dval8, 1);
    ack(8);
    chk("fa_da", mm8, 2); chk("fa_da_ss1", ss8, 6'h33); chk("fa_da_val", dval8, 0);
    @(negedge clk);
    chk("fa_end_mm", mm8, 0); chk("fa_restore", ss8, 6'h10);

    // u8: FIND-ALL-AGG capped at three results
    board_data = 7'h07;
    send(8, 4'hA);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("cap_beat", dout8, 8'h07); chk("cap_val", dval8, 1);
      ack(8);
      if (i < 2) begin
        chk("cap_da", mm8, 2);
        @(negedge clk);
      end
    end
    chk("cap_end_val", dval8, 0); chk("cap_end_mm", mm8, 0);
    chk("cap_restore", ss8, 6'h10);
    @(negedge clk);
    chk("cap_idle_val", dval8, 0);

    // Reset during an FV response
    board_data = 7'h2B;
    send(4, 4'hF);
    @(negedge clk);
    chk("fv_b0", dout4, 4'h2);
    ack(4);
    chk("fv_b1", dout4, 4'hB);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_dout", dout4, 0); chk("mid_rst_val", dval4, 0);
    chk("mid_rst_sm", sm4, 0);     chk("mid_rst_ss1", ss4, 0);
    chk("mid_rst_wtm", wtm4, 0);   chk("mid_rst_err", err4, 0);
    chk("mid_rst_wb", wb4, 0);     chk("mid_rst_mm", mm4, 0);
    @(negedge clk);
    rst_n = 1'b1;
    ack4 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_rst_val", dval4, 0);
    end
    ack4 = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL timeout observed=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end
endmodule
